// File: rtl/alu_cmd_sequencer.sv
// Flow-controlled command front end for the combinational ALU: one command in flight,
// optional accumulator substitution for operand A, captured result returned over valid/ready.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [2:0] OP_RSVD = 3'b111;

    logic [1:0]       state_q,        state_d;
    logic [WIDTH-1:0] alu_a_q,        alu_a_d;
    logic [WIDTH-1:0] alu_b_q,        alu_b_d;
    logic [2:0]       alu_op_q,       alu_op_d;
    logic [WIDTH-1:0] rsp_result_q,   rsp_result_d;
    logic             rsp_zero_q,     rsp_zero_d;
    logic             rsp_carry_q,    rsp_carry_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_err_q,      rsp_err_d;
    logic [WIDTH-1:0] acc_q,          acc_d;
    logic [CNT_W-1:0] done_count_q,   done_count_d;

    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        acc_d          = acc_q;
        done_count_d   = done_count_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    // Reserved opcode never reaches the ALU; answer immediately with an error.
                    if (cmd_op == OP_RSVD) begin
                        rsp_result_d   = '0;
                        rsp_zero_d     = 1'b0;
                        rsp_carry_d    = 1'b0;
                        rsp_overflow_d = 1'b0;
                        rsp_err_d      = 1'b1;
                        state_d        = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                rsp_result_d   = alu_result;
                rsp_zero_d     = alu_zero;
                rsp_carry_d    = alu_carry;
                rsp_overflow_d = alu_overflow;
                rsp_err_d      = 1'b0;
                acc_d          = alu_result;
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            acc_q          <= '0;
            done_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            acc_q          <= acc_d;
            done_count_q   <= done_count_d;
        end
    end

    // Handshake outputs are held low while reset is asserted, whatever the state register says.
    assign cmd_ready    = !rst && (state_q == S_IDLE);
    assign alu_valid    = !rst && (state_q == S_ISSUE);
    assign rsp_valid    = !rst && (state_q == S_RESP);

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign acc          = acc_q;
    assign done_count   = done_count_q;

endmodule
